// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, flag bit positions, iterative-unit modes and FSM states for alu_seq
package alu_seq_pkg;
    localparam int unsigned OP_ADD  = 0;
    localparam int unsigned OP_SUB  = 1;
    localparam int unsigned OP_AND  = 2;
    localparam int unsigned OP_OR   = 3;
    localparam int unsigned OP_XOR  = 4;
    localparam int unsigned OP_NOR  = 5;
    localparam int unsigned OP_SLL  = 6;
    localparam int unsigned OP_SRL  = 7;
    localparam int unsigned OP_SRA  = 8;
    localparam int unsigned OP_SLT  = 9;
    localparam int unsigned OP_SLTU = 10;
    localparam int unsigned OP_MUL  = 11;
    localparam int unsigned OP_DIVU = 12;
    localparam int unsigned OP_REMU = 13;
    localparam int F_Z   = 0;
    localparam int F_C   = 1;
    localparam int F_V   = 2;
    localparam int F_DZ  = 3;
    localparam int F_ILL = 4;
    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;
    typedef enum logic {S_IDLE = 1'b0, S_ITER = 1'b1} state_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: issue-side and writeback-side valid/ready bundle of alu_seq
interface alu_seq_if #(parameter int WIDTH = 32, parameter int OPW = 5);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [4:0]       flags;
    modport master (output in_valid, a, b, opcode, out_ready,
                    input  in_ready, out_valid, result, flags);
    modport slave  (input  in_valid, a, b, opcode, out_ready,
                    output in_ready, out_valid, result, flags);
endinterface

// File: rtl/alu_seq_iter_unit.sv
// alu_seq_iter_unit: WIDTH-step shift-add multiplier / restoring divider; done pulses the cycle after the last step
module alu_seq_iter_unit #(parameter int WIDTH = 32) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    localparam int CW = $clog2(WIDTH);
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] d;
    logic             div_q;
    logic [WIDTH:0]   madd, rsh, rdiff;
    assign madd  = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
    assign rsh   = {hi, lo[WIDTH-1]};
    assign rdiff = rsh - {1'b0, d};
    // mul: {hi,lo} is the right-shifting product; div: hi is the remainder, lo shifts dividend out and quotient in
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            d     <= '0;
            div_q <= 1'b0;
            lo    <= '0;
            hi    <= '0;
        end else begin
            done <= busy && cnt == '0;
            if (start) begin
                busy  <= 1'b1;
                cnt   <= CW'(WIDTH - 1);
                div_q <= mode;
                d     <= b;
                lo    <= a;
                hi    <= '0;
            end else if (busy) begin
                busy <= cnt != '0;
                cnt  <= cnt - 1'b1;
                if (div_q)
                    {hi, lo} <= rdiff[WIDTH] ? {rsh[WIDTH-1:0], lo[WIDTH-2:0], 1'b0}
                                             : {rdiff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
                else
                    {hi, lo} <= {madd, lo[WIDTH-1:1]};
            end
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; single-cycle ops from latched operands, MUL/DIVU/REMU through the shared iterative unit
module alu_seq import alu_seq_pkg::*; #(parameter int WIDTH = 32, parameter int OPW = 5) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, b_q, sc_res, it_res, lo, hi;
    logic [OPW-1:0]   op_q;
    logic [4:0]       sc_fl, it_fl;
    logic [WIDTH:0]   add_s, sub_s;
    logic [SHW-1:0]   sh;
    logic             pend, accept, multi, busy, done;
    int unsigned      opi, opn;
    assign opn    = 32'(bus.opcode);
    assign opi    = 32'(op_q);
    assign multi  = opn == OP_MUL || opn == OP_DIVU || opn == OP_REMU;
    assign accept = bus.in_valid && bus.in_ready;
    assign add_s  = {1'b0, a_q} + {1'b0, b_q};
    assign sub_s  = {1'b0, a_q} + {1'b0, ~b_q} + 1'b1;
    assign sh     = b_q[SHW-1:0];
    assign it_res = opi == OP_REMU ? hi : lo;
    alu_seq_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (accept && multi),
        .mode  (opn == OP_MUL ? MODE_MUL : MODE_DIV),
        .a     (bus.a),
        .b     (bus.b),
        .busy  (busy),
        .done  (done),
        .lo    (lo),
        .hi    (hi)
    );
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n = state == S_IDLE ? (accept && multi ? S_ITER : S_IDLE) : (done ? S_IDLE : S_ITER);
    end
    // pend covers the cycle a single-cycle result is being registered, so it cannot collide with a held output
    always_comb begin
        bus.in_ready = state == S_IDLE && !pend && !busy && (!bus.out_valid || bus.out_ready);
    end
    always_comb begin
        sc_res = '0;
        sc_fl  = '0;
        it_fl  = '0;
        case (opi)
            OP_ADD:  begin
                sc_res       = add_s[WIDTH-1:0];
                sc_fl[F_C]   = add_s[WIDTH];
                sc_fl[F_V]   = a_q[WIDTH-1] == b_q[WIDTH-1] && add_s[WIDTH-1] != a_q[WIDTH-1];
            end
            OP_SUB:  begin
                sc_res       = sub_s[WIDTH-1:0];
                sc_fl[F_C]   = sub_s[WIDTH];
                sc_fl[F_V]   = a_q[WIDTH-1] != b_q[WIDTH-1] && sub_s[WIDTH-1] != a_q[WIDTH-1];
            end
            OP_AND:  sc_res = a_q & b_q;
            OP_OR:   sc_res = a_q | b_q;
            OP_XOR:  sc_res = a_q ^ b_q;
            OP_NOR:  sc_res = ~(a_q | b_q);
            OP_SLL:  sc_res = a_q << sh;
            OP_SRL:  sc_res = a_q >> sh;
            OP_SRA:  sc_res = WIDTH'($signed(a_q) >>> sh);
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, a_q < b_q};
            default: sc_fl[F_ILL] = opi > OP_REMU;
        endcase
        sc_fl[F_Z]  = !sc_fl[F_ILL] && sc_res == '0;
        it_fl[F_DZ] = opi != OP_MUL && b_q == '0;
        it_fl[F_Z]  = it_res == '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.flags     <= '0;
            pend          <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
        end else begin
            pend <= accept && !multi;
            if (accept) begin
                a_q  <= bus.a;
                b_q  <= bus.b;
                op_q <= bus.opcode;
            end
            if (pend) begin
                bus.out_valid <= 1'b1;
                bus.result    <= sc_res;
                bus.flags     <= sc_fl;
            end else if (state == S_ITER && done) begin
                bus.out_valid <= 1'b1;
                bus.result    <= it_res;
                bus.flags     <= it_fl;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule
